// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Default register-address width of the pipeline.
  localparam int REG_AW = 4;

  // Scoreboard rd storage width; any REG_AW up to this value fits.
  localparam int SB_RD_W = 8;

  // Bit positions inside the decoded control-signal word.
  localparam int REG_WRITE_BIT  = 9;
  localparam int MEM_TO_REG_BIT = 8;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match search of one source register against the scoreboard.
// Latency: purely combinational.
// Backpressure: none; the caller decides what a hit means.
module hazard_match #(
  parameter int RD_W         = 8,
  parameter int STAGES       = 3,
  parameter int R0_HARDWIRED = 1,
  parameter int IW           = $clog2(STAGES + 1)
) (
  input  logic [RD_W-1:0]        src,
  input  logic                   use_src,
  input  logic [STAGES-1:0]      ent_valid,
  input  logic [STAGES-1:0]      ent_wr,
  input  logic [STAGES-1:0]      ent_ld,
  input  logic [STAGES*RD_W-1:0] ent_rd,
  output logic                   hit,
  output logic [IW-1:0]          idx,
  output logic                   is_load
);

  logic src_ok;

  // A source that is not read, or is a hardwired r0, can never hit.
  assign src_ok = use_src && !((R0_HARDWIRED != 0) && (src == '0));

  // Scan oldest to youngest so that the youngest (lowest index) match overwrites.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (src_ok && ent_valid[k] && ent_wr[k] && (ent_rd[k*RD_W +: RD_W] == src)) begin
        hit     = 1'b1;
        idx     = IW'(k);
        is_load = ent_ld[k];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard controller: forwarding selects, load-use stall, branch flush, event counters.
// Latency: stall/flush/fwd_sel combinational in the decode cycle; scoreboard and counters update next edge.
// Backpressure: stall holds fetch/decode and bubbles EX; flush (br_taken) overrides stall. HAZ_FWD_EN selects forwarding vs interlock.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW       = pipe_pkg::REG_AW,
  parameter int STAGES       = 3,
  parameter int LOAD_STAGE   = 1,
  parameter int R0_HARDWIRED = 1,
  parameter int CNT_W        = 16,
  parameter int SW           = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [SW-1:0]     fwd_a_sel,
  output logic [SW-1:0]     fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t sb [STAGES];
  sb_entry_t sb_in;

  logic [STAGES-1:0]         ent_valid, ent_wr, ent_ld;
  logic [STAGES*SB_RD_W-1:0] ent_rd;
  logic                      hit_a, hit_b, ld_a, ld_b;
  logic [SW-1:0]             idx_a, idx_b;
  logic                      raw_stall;

  // Flatten the scoreboard into vectors for the match search.
  always_comb begin
    ent_valid = '0;
    ent_wr    = '0;
    ent_ld    = '0;
    ent_rd    = '0;
    for (int k = 0; k < STAGES; k++) begin
      ent_valid[k]                     = sb[k].valid;
      ent_wr[k]                        = sb[k].reg_write;
      ent_ld[k]                        = sb[k].is_load;
      ent_rd[k*SB_RD_W +: SB_RD_W]     = sb[k].rd;
    end
  end

  hazard_match #(.RD_W(SB_RD_W), .STAGES(STAGES), .R0_HARDWIRED(R0_HARDWIRED), .IW(SW)) u_match_a (
    .src(SB_RD_W'(id_rs_a)), .use_src(id_use_a),
    .ent_valid(ent_valid), .ent_wr(ent_wr), .ent_ld(ent_ld), .ent_rd(ent_rd),
    .hit(hit_a), .idx(idx_a), .is_load(ld_a)
  );

  hazard_match #(.RD_W(SB_RD_W), .STAGES(STAGES), .R0_HARDWIRED(R0_HARDWIRED), .IW(SW)) u_match_b (
    .src(SB_RD_W'(id_rs_b)), .use_src(id_use_b),
    .ent_valid(ent_valid), .ent_wr(ent_wr), .ent_ld(ent_ld), .ent_rd(ent_rd),
    .hit(hit_b), .idx(idx_b), .is_load(ld_b)
  );

`ifdef HAZ_FWD_EN
  // Only a load that has not yet reached the load-data stage forces a stall.
  assign raw_stall = (hit_a && ld_a && (idx_a < SW'(LOAD_STAGE))) ||
                     (hit_b && ld_b && (idx_b < SW'(LOAD_STAGE)));
  assign fwd_a_sel = hit_a ? (idx_a + SW'(1)) : SW'(FWD_SEL_RF);
  assign fwd_b_sel = hit_b ? (idx_b + SW'(1)) : SW'(FWD_SEL_RF);
`else
  // Interlock: any in-flight producer of a source holds decode until it retires.
  logic unused_match;
  assign unused_match = ^{ld_a, ld_b, idx_a, idx_b};
  assign raw_stall = hit_a || hit_b;
  assign fwd_a_sel = SW'(FWD_SEL_RF);
  assign fwd_b_sel = SW'(FWD_SEL_RF);
`endif

  // A taken branch kills the stalled consumer anyway, so flush wins.
  assign flush = br_taken;
  assign stall = raw_stall && !br_taken;

  // Decode enters EX only when it is neither held nor killed.
  always_comb begin
    sb_in = '0;
    if (!stall && !flush) begin
      sb_in.valid     = id_valid;
      sb_in.rd        = SB_RD_W'(id_rd);
      sb_in.reg_write = id_reg_write;
      sb_in.is_load   = id_is_load;
    end
  end

  // Shift the scoreboard; a flushed EX instruction arrives in MEM as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) sb[k] <= '0;
    end else begin
      sb[0] <= sb_in;
      for (int k = 1; k < STAGES; k++) begin
        sb[k] <= sb[k-1];
        if (k == 1) sb[k].valid <= sb[k-1].valid && !flush;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomised and directed bench for pipe_hazard_unit against an instruction-history model.
// Latency: checks combinational outputs each decode cycle, registered counters one edge later.
// Backpressure: consumers are re-presented while the model predicts a stall.
module tb_pipe_hazard_unit;

  localparam int REG_AW     = 4;
  localparam int STAGES     = 3;
  localparam int LOAD_STAGE = 1;
  localparam int CNT_W      = 4;
  localparam int SW         = $clog2(STAGES + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_use_a, id_use_b, id_reg_write, id_is_load, br_taken;
  logic [REG_AW-1:0] id_rs_a, id_rs_b, id_rd;
  logic              stall, flush;
  logic [SW-1:0]     fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_hazard_unit #(.REG_AW(REG_AW), .STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE),
                     .R0_HARDWIRED(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .br_taken(br_taken), .stall(stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: the instructions currently past decode, youngest first.
  typedef struct {
    bit alive;
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  instr_t flight[$];
  int     m_stalls, m_flushes;
  int     n_chk, n_fail;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    instr_t nop;
    nop = '{alive: 0, rd: 0, wr: 0, ld: 0};
    flight.delete();
    for (int i = 0; i < STAGES; i++) flight.push_back(nop);
    m_stalls  = 0;
    m_flushes = 0;
  endfunction

  // Age of the youngest in-flight writer of register s, or -1.
  function automatic int producer_age(int s, bit used);
    if (!used || s == 0) return -1;
    for (int age = 0; age < flight.size(); age++)
      if (flight[age].alive && flight[age].wr && flight[age].rd == s) return age;
    return -1;
  endfunction

  function automatic int min_sat(int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One decode cycle: drive, check outputs against the model, optionally reset, advance.
  task automatic cycle(input bit vld, input int rd, input bit wr, input bit ld,
                       input int ra, input bit ua, input int rb, input bit ub,
                       input bit br, input bit do_rst, output bit exp_stall);
    int     pa, pb, efa, efb;
    bit     est;
    instr_t ni;
    @(negedge clk);
    id_valid = vld; id_rd = REG_AW'(rd); id_reg_write = wr; id_is_load = ld;
    id_rs_a = REG_AW'(ra); id_use_a = ua; id_rs_b = REG_AW'(rb); id_use_b = ub;
    br_taken = br;
    #1;
    pa = producer_age(ra, ua);
    pb = producer_age(rb, ub);
`ifdef HAZ_FWD_EN
    efa = pa + 1;
    efb = pb + 1;
    est = (pa >= 0 && flight[pa].ld && pa < LOAD_STAGE) ||
          (pb >= 0 && flight[pb].ld && pb < LOAD_STAGE);
`else
    efa = 0;
    efb = 0;
    est = (pa >= 0) || (pb >= 0);
`endif
    if (br) est = 0;
    exp_stall = est;
    chk("stall", stall, est);
    chk("flush", flush, br);
    chk("fwd_a_sel", fwd_a_sel, efa);
    chk("fwd_b_sel", fwd_b_sel, efb);
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      exp_stall = 0;
      chk("rst_stall", stall, 0);
      chk("rst_flush", flush, br);
      chk("rst_fwd_a", fwd_a_sel, 0);
      chk("rst_fwd_b", fwd_b_sel, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
    end else begin
      @(posedge clk);
      if (est) m_stalls = min_sat(m_stalls + 1);
      if (br) m_flushes = min_sat(m_flushes + 1);
      if (br) flight[0].alive = 0;
      void'(flight.pop_back());
      ni = '{alive: (vld && !est && !br), rd: rd, wr: wr, ld: ld};
      flight.push_front(ni);
    end
  endtask

  // Present an instruction, repeating it while decode is held (bounded).
  task automatic issue(input int rd, input bit wr, input bit ld,
                       input int ra, input bit ua, input int rb, input bit ub, input bit br);
    bit st;
    int tries;
    tries = 0;
    do begin
      cycle(1, rd, wr, ld, ra, ua, rb, ub, br, 0, st);
      tries++;
    end while (st && tries < 8);
    chk("stall_bound", int'(st), 0);
  endtask

  task automatic drain();
    bit st;
    repeat (STAGES) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  initial begin
    bit st;
    rst_n = 1'b0;
    id_valid = 0; id_rd = '0; id_reg_write = 0; id_is_load = 0;
    id_rs_a = '0; id_rs_b = '0; id_use_a = 0; id_use_b = 0; br_taken = 0;
    n_chk = 0; n_fail = 0;
    model_reset();
    #2;
    chk("por_stall", stall, 0);
    chk("por_flush", flush, 0);
    chk("por_fwd_a", fwd_a_sel, 0);
    chk("por_stall_cnt", stall_cnt, 0);
    chk("por_flush_cnt", flush_cnt, 0);
    #10 rst_n = 1'b1;

    // Reset pulsed while a load-use stall is being held.
    cycle(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, st);
    cycle(1, 7, 1, 0, 5, 1, 0, 0, 0, 1, st);
    issue(7, 1, 0, 5, 1, 0, 0, 0);
    drain();

    // ALU RAW at distances 1, 2 and 3.
    issue(3, 1, 0, 1, 0, 2, 0, 0);
    issue(4, 1, 0, 3, 1, 0, 0, 0);
    drain();
    issue(3, 1, 0, 0, 0, 0, 0, 0);
    issue(8, 1, 0, 0, 0, 0, 0, 0);
    issue(9, 1, 0, 3, 1, 0, 0, 0);
    drain();
    issue(3, 1, 0, 0, 0, 0, 0, 0);
    issue(8, 1, 0, 0, 0, 0, 0, 0);
    issue(9, 1, 0, 0, 0, 0, 0, 0);
    issue(10, 1, 0, 1, 1, 3, 1, 0);
    drain();

    // Load-use on rs_a, then on rs_b.
    issue(5, 1, 1, 0, 0, 0, 0, 0);
    issue(6, 1, 0, 5, 1, 0, 0, 0);
    issue(5, 1, 1, 0, 0, 0, 0, 0);
    issue(6, 1, 0, 2, 0, 5, 1, 0);
    drain();

    // Branch taken on the same cycle as a load-use, then a consumer of the flushed rd.
    issue(6, 1, 1, 0, 0, 0, 0, 0);
    issue(7, 1, 0, 6, 1, 0, 0, 1);
    issue(8, 1, 0, 6, 1, 6, 1, 0);
    issue(9, 1, 0, 0, 0, 0, 0, 1);
    issue(10, 1, 0, 0, 0, 0, 0, 1);
    drain();

    // Writes to r0 never create a hazard.
    issue(0, 1, 1, 0, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 1, 0, 1, 0);
    drain();

    // Random traffic on a small register window, with occasional branches and resets.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
